// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller (optional SERIAL_ADDER_OVF_EN adds signed overflow)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shared 1-bit adder cell: two cascaded half adders plus carry OR
  logic h1s, h1c, s_bit, h2c, cy;
  assign h1s   = sa_q[0] ^ sb_q[0];
  assign h1c   = sa_q[0] & sb_q[0];
  assign s_bit = h1s ^ c_q;
  assign h2c   = h1s & c_q;
  assign cy    = h1c | h2c;

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB, captured on the last serial step
  logic cmsb_q, cmsb_d;
`endif

  // Handshake flags decode from state alone
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = cmsb_q ^ cout_q;
`else
  assign ovf = 1'b0;
`endif

  // Next-state logic: load in IDLE, one bit per cycle in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    cmsb_d  = cmsb_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        c_d   = cy;
        sum_d = {s_bit, sum_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = cy;
`ifdef SERIAL_ADDER_OVF_EN
          cmsb_d  = c_q;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // MSB carry-in flop used to derive signed overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmsb_q <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
    end
  end
`endif

endmodule
